// File: rtl/tone_pkg.sv
// tone_pkg: shared states, note width and game-over melody for the tone scheduler
package tone_pkg;
  localparam int NUM_W = 2;
  localparam int MELODY_LEN = 4;
  localparam logic [MELODY_LEN-1:0][NUM_W-1:0] MELODY_NOTES = {2'd0, 2'd1, 2'd2, 2'd3};
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIMON_ON,
    ST_PLAYER_ON,
    ST_GAP,
    ST_MELODY,
    ST_DONE
  } state_t;
endpackage

// File: rtl/tone_scheduler_if.sv
// tone_scheduler_if: requester side (master) and scheduler side (slave) of the tone datapath
interface tone_scheduler_if;
  import tone_pkg::*;
  logic simon_req, player_pressed, game_over;
  logic pressed, jingle, simon_ack, simon_done, busy;
  logic [NUM_W-1:0] simon_num, player_num, num;
  modport master (
    output simon_req, simon_num, player_pressed, player_num, game_over,
    input  num, pressed, jingle, simon_ack, simon_done, busy
  );
  modport slave (
    input  simon_req, simon_num, player_pressed, player_num, game_over,
    output num, pressed, jingle, simon_ack, simon_done, busy
  );
endinterface

// File: rtl/tone_timer.sv
// tone_timer: loadable down-counter that parks at zero instead of wrapping
module tone_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? value : cnt - W'(cnt != '0);
  assign zero = cnt == '0;
endmodule

// File: rtl/tone_scheduler.sv
// tone_scheduler: arbitrates Simon, player and game-over jingle onto the shared tone/LED path
module tone_scheduler
  import tone_pkg::*;
#(
  parameter int MIN_ON   = 12_500_000,
  parameter int GAP      = 2_500_000,
  parameter int NOTE_LEN = 6_250_000
) (
  input logic clk,
  input logic reset,
  tone_scheduler_if.slave bus
);
  localparam int MAX_T = MIN_ON > GAP ? (MIN_ON > NOTE_LEN ? MIN_ON : NOTE_LEN)
                                      : (GAP > NOTE_LEN ? GAP : NOTE_LEN);
  localparam int TW = $clog2(MAX_T + 1);
  localparam int IW = $clog2(MELODY_LEN);
  state_t state, nxt, grant;
  logic [TW-1:0] load_val;
  logic load, zero, adv, fresh, from_simon;
  logic [NUM_W-1:0] note, num_d;
  logic [IW-1:0] idx;
  logic pressed_d, jingle_d, ack_d, done_d, busy_d;
  tone_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (reset),
    .load (load),
    .value(load_val),
    .zero (zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      fresh          <= 1'b0;
      note           <= '0;
      from_simon     <= 1'b0;
      idx            <= '0;
      bus.num        <= '0;
      bus.pressed    <= 1'b0;
      bus.jingle     <= 1'b0;
      bus.simon_ack  <= 1'b0;
      bus.simon_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state <= nxt;
      fresh <= nxt != state;
      if (nxt == ST_SIMON_ON && state != ST_SIMON_ON) begin
        note       <= bus.simon_num;
        from_simon <= 1'b1;
      end else if (nxt == ST_PLAYER_ON && state != ST_PLAYER_ON) begin
        note       <= bus.player_num;
        from_simon <= 1'b0;
      end
      idx            <= nxt != ST_MELODY ? '0 : idx + IW'(adv);
      bus.num        <= num_d;
      bus.pressed    <= pressed_d;
      bus.jingle     <= jingle_d;
      bus.simon_ack  <= ack_d;
      bus.simon_done <= done_d;
      bus.busy       <= busy_d;
    end
  end
  // GAP exit arbitrates like IDLE so a held press follows simon_done without a dead cycle
  always_comb begin
    grant = bus.simon_req ? ST_SIMON_ON : bus.player_pressed ? ST_PLAYER_ON : ST_IDLE;
    nxt   = state;
    adv   = 1'b0;
    case (state)
      ST_IDLE:      nxt = grant;
      ST_SIMON_ON:  nxt = zero ? ST_GAP : state;
      ST_PLAYER_ON: nxt = zero && !bus.player_pressed ? ST_GAP : state;
      ST_GAP:       nxt = zero ? grant : state;
      ST_MELODY: begin
        nxt = zero && idx == IW'(MELODY_LEN - 1) ? ST_DONE : state;
        adv = zero && idx != IW'(MELODY_LEN - 1);
      end
      default:      nxt = state;
    endcase
    if (bus.game_over && state != ST_DONE && state != ST_MELODY) nxt = ST_MELODY;
    load     = nxt != state || adv;
    load_val = (nxt == ST_SIMON_ON || nxt == ST_PLAYER_ON) ? TW'(MIN_ON - 1)
             : nxt == ST_GAP ? TW'(GAP - 1)
             : nxt == ST_MELODY ? TW'(NOTE_LEN - 1) : '0;
  end
  always_comb begin
    pressed_d = state inside {ST_SIMON_ON, ST_PLAYER_ON, ST_MELODY};
    jingle_d  = state == ST_MELODY;
    num_d     = jingle_d ? MELODY_NOTES[idx] : pressed_d ? note : '0;
    ack_d     = state == ST_SIMON_ON && fresh;
    done_d    = state == ST_GAP && zero && from_simon && !bus.game_over;
    busy_d    = !(state inside {ST_IDLE, ST_DONE});
  end
endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: scoreboard of per-cycle expected output vectors against the scheduler
module tb_tone_scheduler;
  logic clk = 1'b0;
  logic reset;
  tone_scheduler_if bus ();
  tone_scheduler #(.MIN_ON(4), .GAP(2), .NOTE_LEN(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [6:0] sb[$];
  int sr_at, pp_from, pp_to, go_from, go_to, rs_from, rs_to;
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  // vector layout {busy, jingle, pressed, num[1:0], simon_ack, simon_done}
  function automatic logic [6:0] v(input logic b, j, p, input logic [1:0] n, input logic a, d);
    return {b, j, p, n, a, d};
  endfunction
  task automatic expect_n(input logic [6:0] val, input int n);
    repeat (n) sb.push_back(val);
  endtask
  task automatic arm(input int s, pf, pt, gf, gt, rf, rt);
    sr_at = s; pp_from = pf; pp_to = pt; go_from = gf; go_to = gt; rs_from = rf; rs_to = rt;
    bus.simon_req = 1'b0;
  endtask
  task automatic run(input string name, input int n);
    logic [6:0] obs;
    for (int cy = 0; cy < n; cy++) begin
      @(negedge clk);
      obs = {bus.busy, bus.jingle, bus.pressed, bus.pressed ? bus.num : 2'b00,
             bus.simon_ack, bus.simon_done};
      if (sb.size() > 0) check($sformatf("%s@%0d", name, cy), obs, sb.pop_front());
      if (obs[1]) bus.simon_req = 1'b0;
      else if (cy == sr_at) bus.simon_req = 1'b1;
      bus.player_pressed = cy >= pp_from && cy < pp_to;
      bus.player_num     = cy == pp_from + 1 ? 2'd3 : 2'd1;
      bus.game_over      = cy >= go_from && cy < go_to;
      reset              = cy >= rs_from && cy < rs_to;
    end
    if (sb.size() != 0) begin
      check({name, "-drain"}, 7'(sb.size()), 7'd0);
      sb.delete();
    end
  endtask
  initial begin
    logic [6:0] sim_ack, sim_on, gap_v, gap_d, ply;
    sim_ack = v(1, 0, 1, 2, 1, 0);
    sim_on  = v(1, 0, 1, 2, 0, 0);
    gap_v   = v(1, 0, 0, 0, 0, 0);
    gap_d   = v(1, 0, 0, 0, 0, 1);
    ply     = v(1, 0, 1, 1, 0, 0);
    reset = 1'b1;
    bus.simon_req = 1'b0; bus.simon_num = 2'd2;
    bus.player_pressed = 1'b0; bus.player_num = 2'd1; bus.game_over = 1'b0;
    arm(-1, -1, -1, -1, -1, -1, -1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_n(7'd0, 4);
    run("reset", 4);
    arm(0, -1, -1, -1, -1, -1, -1);
    expect_n(7'd0, 2); expect_n(sim_ack, 1); expect_n(sim_on, 3);
    expect_n(gap_v, 1); expect_n(gap_d, 1); expect_n(7'd0, 2);
    run("simon", 10);
    arm(-1, 0, 1, -1, -1, -1, -1);
    expect_n(7'd0, 2); expect_n(ply, 4); expect_n(gap_v, 2); expect_n(7'd0, 2);
    run("short", 10);
    arm(-1, 0, 10, -1, -1, -1, -1);
    expect_n(7'd0, 2); expect_n(ply, 10); expect_n(gap_v, 2); expect_n(7'd0, 2);
    run("long", 16);
    arm(0, 0, 20, -1, -1, -1, -1);
    expect_n(7'd0, 2); expect_n(sim_ack, 1); expect_n(sim_on, 3);
    expect_n(gap_v, 1); expect_n(gap_d, 1); expect_n(ply, 14);
    expect_n(gap_v, 2); expect_n(7'd0, 2);
    run("both", 26);
    arm(0, -1, -1, 2, 100, -1, -1);
    expect_n(7'd0, 2); expect_n(sim_ack, 1); expect_n(sim_on, 1);
    for (int i = 3; i >= 0; i--) expect_n(v(1, 1, 1, 2'(i), 0, 0), 3);
    expect_n(7'd0, 8);
    run("gameover", 24);
    arm(2, -1, -1, -1, -1, 0, 2);
    expect_n(7'd0, 4); expect_n(sim_ack, 1); expect_n(sim_on, 3);
    expect_n(gap_v, 1); expect_n(gap_d, 1); expect_n(7'd0, 2);
    run("redo", 12);
    arm(-1, -1, -1, 0, 1, 0, 1);
    expect_n(7'd0, 5);
    run("rstwins", 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
